// File: rtl/toggle_mux_arbiter.sv
// Two-requester round-robin arbiter driving a shared m/n output mux.
// Grants are bounded to MAX_BURST beats so neither side can starve the other.
module toggle_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_m,
    input  logic             last_m,
    input  logic [WIDTH-1:0] m,
    input  logic             req_n,
    input  logic             last_n,
    input  logic [WIDTH-1:0] n,
    output logic             gnt_m,
    output logic             gnt_n,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LIMIT = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_M = 2'd1,
        GNT_N = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            pri_q, pri_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            sel_q, sel_d;

    logic            rel_m;
    logic            rel_n;
    logic            at_limit;

    assign at_limit = (beat_q == LIMIT);

    // A withdrawn request releases too; last is only meaningful with req.
    assign rel_m = !req_m || last_m || at_limit;
    assign rel_n = !req_n || last_n || at_limit;

    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        beat_d  = beat_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (req_m && (!req_n || !pri_q)) begin
                    state_d = GNT_M;
                    sel_d   = 1'b0;
                    beat_d  = '0;
                end else if (req_n) begin
                    state_d = GNT_N;
                    sel_d   = 1'b1;
                    beat_d  = '0;
                end
            end
            GNT_M: begin
                if (rel_m) begin
                    pri_d  = 1'b1;
                    beat_d = '0;
                    if (req_n) begin
                        state_d = GNT_N;
                        sel_d   = 1'b1;
                    end else if (req_m) begin
                        state_d = GNT_M;
                        sel_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            GNT_N: begin
                if (rel_n) begin
                    pri_d  = 1'b0;
                    beat_d = '0;
                    if (req_m) begin
                        state_d = GNT_M;
                        sel_d   = 1'b0;
                    end else if (req_n) begin
                        state_d = GNT_N;
                        sel_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pri_q   <= 1'b0;
            beat_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            beat_q  <= beat_d;
            sel_q   <= sel_d;
        end
    end

    assign gnt_m = (state_q == GNT_M);
    assign gnt_n = (state_q == GNT_N);
    assign sel   = sel_q;

    always_comb begin
        y = '0;
        unique case (state_q)
            GNT_M:   y = m;
            GNT_N:   y = n;
            default: y = '0;
        endcase
    end

    assign y_valid = (gnt_m && req_m) || (gnt_n && req_n);

endmodule

// File: tb/tb_toggle_mux_arbiter.sv
// Directed bench for toggle_mux_arbiter: reset, bursts, fairness,
// early last, withdrawal and mid-burst reset.
module tb_toggle_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_m, last_m, req_n, last_n;
    logic [7:0] m, n;
    logic       gnt_m, gnt_n, sel, y_valid;
    logic [7:0] y;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    toggle_mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_m   (req_m),
        .last_m  (last_m),
        .m       (m),
        .req_n   (req_n),
        .last_n  (last_n),
        .n       (n),
        .gnt_m   (gnt_m),
        .gnt_n   (gnt_n),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic egm, input logic egn,
                           input logic esel, input logic [7:0] ey,
                           input logic ev);
        n_total++;
        assert (gnt_m === egm) n_pass++;
        else $error("FAIL %s.gnt_m: observed %b expected %b", tag, gnt_m, egm);
        n_total++;
        assert (gnt_n === egn) n_pass++;
        else $error("FAIL %s.gnt_n: observed %b expected %b", tag, gnt_n, egn);
        n_total++;
        assert (sel === esel) n_pass++;
        else $error("FAIL %s.sel: observed %b expected %b", tag, sel, esel);
        n_total++;
        assert (y === ey) n_pass++;
        else $error("FAIL %s.y: observed %h expected %h", tag, y, ey);
        n_total++;
        assert (y_valid === ev) n_pass++;
        else $error("FAIL %s.y_valid: observed %b expected %b", tag, y_valid, ev);
    endtask

    always @(negedge clk) begin
        n_total++;
        assert (!(gnt_m && gnt_n)) n_pass++;
        else $error("FAIL mutex: observed gnt_m=%b gnt_n=%b expected not both",
                    gnt_m, gnt_n);
    end

    initial begin
        rst    = 1'b1;
        req_m  = 1'b1;
        req_n  = 1'b1;
        last_m = 1'b0;
        last_n = 1'b0;
        m      = 8'hA5;
        n      = 8'h5A;

        // Reset held two cycles with both sides requesting
        tick;
        tick;
        settle;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Release: pri=0 so m wins
        rst = 1'b0;
        tick;
        req_n = 1'b0;
        settle;
        chk_all("single0", 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick;
            settle;
            chk_all("single", 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1);
        end

        // Fairness: m starts a fresh burst here, then 4/4 alternation
        tick;
        m     = 8'h11;
        n     = 8'h22;
        req_n = 1'b1;
        settle;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) begin
                tick;
                settle;
            end
            if (((i / 4) % 2) == 0)
                chk_all("fair_m", 1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
            else
                chk_all("fair_n", 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
        end

        // Early last on 2nd m beat
        tick;
        settle;
        chk_all("last_b0", 1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
        tick;
        last_m = 1'b1;
        settle;
        chk_all("last_b1", 1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
        tick;
        last_m = 1'b0;
        req_m  = 1'b0;
        settle;
        chk_all("last_hand", 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);

        // Withdrawal of n with m idle
        tick;
        req_n = 1'b0;
        settle;
        chk_all("wd_drop", 1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
        tick;
        settle;
        chk_all("wd_idle", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        req_n = 1'b1;
        settle;
        chk_all("wd_idle_req", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        tick;
        settle;
        chk_all("wd_regnt", 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
        tick;
        settle;
        chk_all("n_beat1", 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);

        // Reset during beat 2 of the n burst
        tick;
        rst = 1'b1;
        settle;
        chk_all("n_beat2", 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
        tick;
        settle;
        chk_all("rst_mid", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        rst   = 1'b0;
        req_m = 1'b1;
        settle;

        // pri cleared: m first, full burst, then n
        for (int i = 0; i < 4; i++) begin
            tick;
            settle;
            chk_all("rst_pri_m", 1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
        end
        tick;
        settle;
        chk_all("rst_pri_n", 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
